cdb_arbiter: RTL

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_pkg.sv | 28 ++
 rtl/cdb_arbiter_if.sv | 31 +++
 rtl/cdb_arbiter_rr_arbiter.sv | 41 ++++
 rtl/cdb_arbiter.sv | 95 +++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// rv32i_types : shared core types -- CDB payload and functional-unit indices
// Rev 1.0
// ============================================================================
package rv32i_types;

  localparam int NUM_CDB_SRC = 5;

  localparam int SRC_ALU    = 0;
  localparam int SRC_MUL    = 1;
  localparam int SRC_DIV    = 2;
  localparam int SRC_MEM    = 3;
  localparam int SRC_BRANCH = 4;

  localparam int XLEN       = 32;
  localparam int ROB_IDX_W  = 5;
  localparam int ARCH_REG_W = 5;

  typedef struct packed {
    logic                  valid;
    logic [ROB_IDX_W-1:0]  rob_idx;
    logic [ARCH_REG_W-1:0] rd_s;
    logic [XLEN-1:0]       rd_v;
  } cdb_t;

endpackage
`default_nettype wire

// File: rtl/cdb_arbiter_if.sv
`default_nettype none
// ============================================================================
// cdb_arbiter_if : result-source handshake and CDB broadcast bundle
// Rev 1.0
// ============================================================================
interface cdb_arbiter_if #(
  parameter int NUM_CDB_SRC = rv32i_types::NUM_CDB_SRC
);
  import rv32i_types::*;

  logic [NUM_CDB_SRC-1:0] src_valid;
  cdb_t                   src_data [NUM_CDB_SRC];
  logic [NUM_CDB_SRC-1:0] src_ready;
  cdb_t                   cdb_out;

  modport master (
    output src_valid,
    output src_data,
    input  src_ready,
    input  cdb_out
  );

  modport slave (
    input  src_valid,
    input  src_data,
    output src_ready,
    output cdb_out
  );

endinterface
`default_nettype wire

// File: rtl/cdb_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : combinational round-robin pick, starting the search at ptr
// Rev 1.0
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ = 5,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_any
);

  always_comb begin
    logic [IDX_W-1:0] cand;
    int               sum;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    sum     = 0;
    // Walk ptr, ptr+1, ... modulo NUM_REQ; the first requester found wins.
    for (int off = 0; off < NUM_REQ; off++) begin
      sum = int'(ptr) + off;
      if (sum >= NUM_REQ) begin
        sum = sum - NUM_REQ;
      end
      cand = IDX_W'(sum);
      if (!gnt_any && req[cand]) begin
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
        gnt_any   = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// cdb_arbiter : one holding slot per functional unit, round-robin onto the CDB
// Rev 1.0
// ============================================================================
module cdb_arbiter #(
  parameter int NUM_CDB_SRC = rv32i_types::NUM_CDB_SRC
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  cdb_arbiter_if.slave bus
);
  import rv32i_types::*;

  localparam int               IDX_W    = (NUM_CDB_SRC > 1) ? $clog2(NUM_CDB_SRC) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CDB_SRC - 1);

  logic [NUM_CDB_SRC-1:0] slot_valid_q;
  logic [NUM_CDB_SRC-1:0] slot_valid_d;
  cdb_t                   slot_data_q [NUM_CDB_SRC];
  cdb_t                   slot_data_d [NUM_CDB_SRC];
  logic [IDX_W-1:0]       rr_ptr_q;
  logic [IDX_W-1:0]       rr_ptr_d;
  cdb_t                   cdb_out_q;
  cdb_t                   cdb_out_d;

  logic [NUM_CDB_SRC-1:0] grant;
  logic [IDX_W-1:0]       grant_idx;
  logic                   grant_any;
  logic [NUM_CDB_SRC-1:0] src_ready;
  logic [NUM_CDB_SRC-1:0] accept;

  rr_arbiter #(
    .NUM_REQ (NUM_CDB_SRC),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req     (slot_valid_q),
    .ptr     (rr_ptr_q),
    .gnt     (grant),
    .gnt_idx (grant_idx),
    .gnt_any (grant_any)
  );

  // A slot being drained this cycle can take a new result in the same cycle.
  assign src_ready     = (~slot_valid_q | grant) & {NUM_CDB_SRC{~flush & rst_n}};
  assign accept        = bus.src_valid & src_ready;
  assign bus.src_ready = src_ready;
  assign bus.cdb_out   = cdb_out_q;

  always_comb begin
    slot_valid_d = slot_valid_q;
    for (int i = 0; i < NUM_CDB_SRC; i++) begin
      slot_data_d[i] = slot_data_q[i];
      if (flush) begin
        slot_valid_d[i] = 1'b0;
      end else if (accept[i]) begin
        slot_valid_d[i] = 1'b1;
        slot_data_d[i]  = bus.src_data[i];
      end else if (grant[i]) begin
        slot_valid_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    cdb_out_d = '0;
    rr_ptr_d  = rr_ptr_q;
    if (!flush && grant_any) begin
      cdb_out_d       = slot_data_q[grant_idx];
      cdb_out_d.valid = 1'b1;
      rr_ptr_d        = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_valid_q <= '0;
      rr_ptr_q     <= '0;
      cdb_out_q    <= '0;
      for (int i = 0; i < NUM_CDB_SRC; i++) begin
        slot_data_q[i] <= '0;
      end
    end else begin
      slot_valid_q <= slot_valid_d;
      rr_ptr_q     <= rr_ptr_d;
      cdb_out_q    <= cdb_out_d;
      for (int i = 0; i < NUM_CDB_SRC; i++) begin
        slot_data_q[i] <= slot_data_d[i];
      end
    end
  end

endmodule
`default_nettype wire
